// File: rtl/vector_control_unit_pkg.sv
// Shared types and ISA decode constants for the SIMD AES vector control unit.
package cu_pkg;

  typedef struct packed {
    logic       PCSrc;
    logic       RegWrite;
    logic       RegWriteV;
    logic       MemtoReg;
    logic       MemWrite;
    logic       ALUSel;
    logic       Branch;
    logic       ALUSrc;
    logic       MemSrc;
    logic [2:0] ALUControl;
    logic [1:0] FlagWrite;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] MemData;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCALAR = 2'd1,
    ST_VEC    = 2'd2
  } cu_state_e;

  // Opcode[5:4] selects the instruction class.
  localparam logic [1:0] OPC_CLASS_ALU  = 2'b00;
  localparam logic [1:0] OPC_CLASS_MEM  = 2'b01;
  localparam logic [1:0] OPC_CLASS_CTRL = 2'b10;
  localparam logic [1:0] OPC_VEC_CLASS  = 2'b11;

  localparam logic [5:0] OPC_NOP    = 6'h00;
  localparam logic [5:0] OPC_ALU    = 6'h01;
  localparam logic [5:0] OPC_ALUI   = 6'h02;
  localparam logic [5:0] OPC_LOAD   = 6'h10;
  localparam logic [5:0] OPC_STORE  = 6'h11;
  localparam logic [5:0] OPC_BRANCH = 6'h20;
  localparam logic [5:0] OPC_VALU   = 6'h30;
  localparam logic [5:0] OPC_VLOAD  = 6'h31;
  localparam logic [5:0] OPC_VSTORE = 6'h32;
  localparam logic [5:0] OPC_VAES   = 6'h33;

  localparam logic [2:0] ALU_CMP     = 3'b001;
  localparam logic [1:0] IMM_ALU     = 2'b00;
  localparam logic [1:0] IMM_MEM     = 2'b01;
  localparam logic [1:0] IMM_BRANCH  = 2'b10;
  localparam logic [1:0] REGSRC_BR   = 2'b01;
  localparam logic [1:0] REGSRC_ST   = 2'b10;
  localparam logic [1:0] MEMDATA_VEC = 2'b11;

endpackage

// File: rtl/vector_control_unit_decode.sv
// Combinational ISA decode from opcode/function fields into a ctrl_t bundle.
module cu_decode
  import cu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [2:0] func_i,
  output ctrl_t      ctrl_o,
  output logic       isVec_o
);

  assign isVec_o = (opcode_i[5:4] == OPC_VEC_CLASS);

  // PCSrc depends on Rd, so it is resolved by the top level, not here.
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OPC_ALU: begin
        ctrl_o.RegWrite   = 1'b1;
        ctrl_o.ALUControl = func_i;
        ctrl_o.FlagWrite  = 2'b11;
      end
      OPC_ALUI: begin
        ctrl_o.RegWrite   = 1'b1;
        ctrl_o.ALUSrc     = 1'b1;
        ctrl_o.ALUControl = func_i;
        ctrl_o.FlagWrite  = 2'b01;
        ctrl_o.ImmSrc     = IMM_ALU;
      end
      OPC_LOAD: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.MemtoReg = 1'b1;
        ctrl_o.ALUSrc   = 1'b1;
        ctrl_o.ImmSrc   = IMM_MEM;
        ctrl_o.MemData  = func_i[1:0];
      end
      OPC_STORE: begin
        ctrl_o.MemWrite = 1'b1;
        ctrl_o.ALUSrc   = 1'b1;
        ctrl_o.ImmSrc   = IMM_MEM;
        ctrl_o.RegSrc   = REGSRC_ST;
        ctrl_o.MemData  = func_i[1:0];
      end
      OPC_BRANCH: begin
        ctrl_o.Branch     = 1'b1;
        ctrl_o.ALUControl = ALU_CMP;
        ctrl_o.ImmSrc     = IMM_BRANCH;
        ctrl_o.RegSrc     = REGSRC_BR;
      end
      OPC_VALU: begin
        ctrl_o.RegWriteV  = 1'b1;
        ctrl_o.ALUControl = func_i;
        ctrl_o.FlagWrite  = 2'b11;
      end
      OPC_VLOAD: begin
        ctrl_o.RegWriteV = 1'b1;
        ctrl_o.MemtoReg  = 1'b1;
        ctrl_o.ALUSrc    = 1'b1;
        ctrl_o.MemSrc    = 1'b1;
        ctrl_o.ImmSrc    = IMM_MEM;
        ctrl_o.MemData   = MEMDATA_VEC;
      end
      OPC_VSTORE: begin
        ctrl_o.MemWrite = 1'b1;
        ctrl_o.ALUSrc   = 1'b1;
        ctrl_o.MemSrc   = 1'b1;
        ctrl_o.ImmSrc   = IMM_MEM;
        ctrl_o.RegSrc   = REGSRC_ST;
        ctrl_o.MemData  = MEMDATA_VEC;
      end
      OPC_VAES: begin
        ctrl_o.RegWriteV  = 1'b1;
        ctrl_o.ALUSel     = 1'b1;
        ctrl_o.ALUControl = func_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_control_unit.sv
// Decode/execute control unit: scalar issue, BEATS-long vector sequencing, flush.
// Define CU_PERF_CNT_EN to add saturating vector-issue and stall-cycle counters.
module vector_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter logic [4:0]  PC_IDX = 5'd31,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         InstrValid,
  input  logic [5:0]                                   Opcode,
  input  logic [2:0]                                   Func,
  input  logic [4:0]                                   Rd,
  input  logic                                         Flush,
  output logic                                         Stall,
  output logic                                         CtrlValid,
  output logic                                         PCSrc,
  output logic                                         RegWrite,
  output logic                                         RegWriteV,
  output logic                                         MemtoReg,
  output logic                                         MemWrite,
  output logic                                         ALUSel,
  output logic                                         Branch,
  output logic                                         ALUSrc,
  output logic                                         MemSrc,
  output logic [2:0]                                   ALUControl,
  output logic [1:0]                                   FlagWrite,
  output logic [1:0]                                   ImmSrc,
  output logic [1:0]                                   RegSrc,
  output logic [1:0]                                   MemData,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] BeatIdx,
  output logic [BEATS-1:0]                             LaneMask,
  output logic                                         LastBeat
`ifdef CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                             PerfVecCnt,
  output logic [CNT_W-1:0]                             PerfStallCnt
`endif
);

  localparam int unsigned   BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  cu_state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  ctrl_t ctrl_q, ctrl_d;

  ctrl_t decCtrl;
  ctrl_t issueCtrl;
  ctrl_t ctrlOut;
  logic  decIsVec;
  logic  accept;
  logic  vecLast;

  cu_decode u_decode (
    .opcode_i (Opcode),
    .func_i   (Func),
    .ctrl_o   (decCtrl),
    .isVec_o  (decIsVec)
  );

  assign accept  = InstrValid && !Stall && !Flush;
  assign vecLast = (beat_q == LAST_BEAT);

  // Vector ops never redirect; scalar redirect covers branches and writes to the PC register.
  always_comb begin
    issueCtrl = decCtrl;
    if (decIsVec) begin
      issueCtrl.Branch = 1'b0;
      issueCtrl.PCSrc  = 1'b0;
    end else begin
      issueCtrl.PCSrc = decCtrl.Branch | (decCtrl.RegWrite && (Rd == PC_IDX));
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ctrl_d  = ctrl_q;
    if (Flush) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      ctrl_d  = '0;
    end else if (accept) begin
      state_d = decIsVec ? ST_VEC : ST_SCALAR;
      beat_d  = '0;
      ctrl_d  = issueCtrl;
    end else if (state_q == ST_VEC && !vecLast) begin
      beat_d = beat_q + BW'(1);
    end else begin
      state_d = ST_IDLE;
      beat_d  = '0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Flag updates are held back until the final lane slice has been processed.
  always_comb begin
    ctrlOut   = '0;
    CtrlValid = 1'b0;
    Stall     = 1'b0;
    LastBeat  = 1'b0;
    BeatIdx   = '0;
    LaneMask  = '0;
    case (state_q)
      ST_SCALAR: begin
        ctrlOut   = ctrl_q;
        CtrlValid = 1'b1;
        LastBeat  = 1'b1;
        LaneMask  = '1;
      end
      ST_VEC: begin
        ctrlOut   = ctrl_q;
        CtrlValid = 1'b1;
        LastBeat  = vecLast;
        Stall     = !vecLast;
        BeatIdx   = beat_q;
        LaneMask  = BEATS'(1) << beat_q;
        if (!vecLast) ctrlOut.FlagWrite = '0;
      end
      default: ;
    endcase
  end

  assign PCSrc      = ctrlOut.PCSrc;
  assign RegWrite   = ctrlOut.RegWrite;
  assign RegWriteV  = ctrlOut.RegWriteV;
  assign MemtoReg   = ctrlOut.MemtoReg;
  assign MemWrite   = ctrlOut.MemWrite;
  assign ALUSel     = ctrlOut.ALUSel;
  assign Branch     = ctrlOut.Branch;
  assign ALUSrc     = ctrlOut.ALUSrc;
  assign MemSrc     = ctrlOut.MemSrc;
  assign ALUControl = ctrlOut.ALUControl;
  assign FlagWrite  = ctrlOut.FlagWrite;
  assign ImmSrc     = ctrlOut.ImmSrc;
  assign RegSrc     = ctrlOut.RegSrc;
  assign MemData    = ctrlOut.MemData;

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] perfVec_q, perfStall_q;

  // Counters saturate rather than wrap so a long run never reports a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfVec_q   <= '0;
      perfStall_q <= '0;
    end else begin
      if (accept && decIsVec && perfVec_q != '1) perfVec_q <= perfVec_q + CNT_W'(1);
      if (Stall && perfStall_q != '1) perfStall_q <= perfStall_q + CNT_W'(1);
    end
  end

  assign PerfVecCnt   = perfVec_q;
  assign PerfStallCnt = perfStall_q;
`endif

endmodule

// File: doc/vector_control_unit.md
# vector_control_unit

Sequential, parametrised control unit for the SIMD AES datapath. It sits between decode and execute. It registers decoded control signals for scalar instructions. It sequences each vector instruction over `BEATS` consecutive lane-slice beats, stalling fetch/decode until the final beat issues. It also handles pipeline flush and PC-write redirect, and optionally keeps performance counters.

## Interface
Parameters:
- `BEATS`, 4: beats per vector instruction; power of two, 1–16.
- `PC_IDX`, 5'd31: register index treated as the PC; a write to it redirects the PC.
- `CNT_W`, 32: performance counter width; used only with the macro.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `InstrValid` in 1: decode presents a valid instruction.
- `Opcode` in 6, `Func` in 3, `Rd` in 5: instruction fields.
- `Flush` in 1: squash the current and in-flight instruction.
- `Stall` out 1: hold fetch/decode; the instruction fields must stay stable.
- `CtrlValid` out 1: the registered control outputs are valid this cycle.
- `PCSrc`, `RegWrite`, `RegWriteV`, `MemtoReg`, `MemWrite`, `ALUSel`, `Branch`, `ALUSrc`, `MemSrc` out 1 each: registered control.
- `ALUControl` out 3, `FlagWrite` out 2, `ImmSrc` out 2, `RegSrc` out 2, `MemData` out 2: registered control.
- `BeatIdx` out $clog2(BEATS) (min 1): current beat number.
- `LaneMask` out BEATS: one-hot lane slice enable.
- `LastBeat` out 1: the current beat is the final beat.
- `PerfVecCnt`, `PerfStallCnt` out CNT_W: present only with `CU_PERF_CNT_EN`.

## Operation
- Decoding is combinational, from `Opcode`/`Func` using the ISA table in `cu_pkg`, into a `ctrl_t` struct. Opcode class `Opcode[5:4]==2'b11` is vector; all other opcodes are scalar.
- FSM states:
  - `IDLE`: no instruction.
  - `SCALAR`: one-cycle issue.
  - `VEC`: beat loop.
- Transitions:
  - From any state, with `InstrValid`, no `Stall` and no `Flush`: a scalar instruction goes to `SCALAR`; a vector instruction goes to `VEC` with beat 0.
  - From `SCALAR` or from `VEC` at the last beat: go to the next instruction if `InstrValid`, otherwise `IDLE`.
- Scalar issue:
  - The registered `ctrl_t` drives the outputs.
  - `LaneMask` = all ones, `BeatIdx`=0, `LastBeat`=1.
- Vector issue:
  - Control is latched once at beat 0.
  - `BeatIdx` increments each cycle, and `LaneMask` = `1<<BeatIdx`.
  - `RegWriteV`/`MemWrite` are asserted on every beat.
  - `FlagWrite` is nonzero only on the last beat.
  - `Branch`/`PCSrc` are forced 0 for vector ops.
- `Stall` = (state==`VEC`) && !`LastBeat`.
- `PCSrc` = `Branch` | (`RegWrite` && `Rd`==`PC_IDX`). It is registered with the other controls.
- Arithmetic:
  - The beat counter is unsigned and wraps from BEATS-1 to 0 only at a new issue.
  - With `BEATS`=1, a vector op behaves like a scalar op with `RegWriteV` set.

## Timing
- Latency: outputs are valid one cycle after the issuing edge (`CtrlValid`=1).
- A vector instruction occupies exactly `BEATS` cycles. `Stall` is high for the first BEATS-1 of them.
- Back-to-back issue:
  - A new instruction is accepted on the edge where `LastBeat`=1, so there are no bubbles.
  - A scalar instruction following a scalar instruction issues every cycle.
- `Flush`:
  - Synchronous.
  - Next cycle: state `IDLE`, all control outputs 0, `CtrlValid`=0, `Stall`=0.
  - `Flush` has priority over a simultaneous `InstrValid`, and over a vector op mid-beat.
- `InstrValid` while `Stall`=1 is ignored; the held fields belong to the in-flight op.
- Reset (async, `rst_n`=0), effective immediately:
  - State `IDLE`.
  - All control outputs, `CtrlValid`, `Stall`, `BeatIdx`, `LaneMask` and `LastBeat` = 0.
  - Counters = 0.
  - Reset mid-vector abandons the remaining beats.

## Configuration
- `CU_PERF_CNT_EN` defined:
  - `PerfVecCnt` increments once per accepted vector instruction.
  - `PerfStallCnt` increments on each cycle with `Stall`=1.
  - Both saturate at all-ones and clear only on reset.
- Macro undefined: the counter ports and logic are absent, and the remaining behaviour is identical.

## Structure
- `cu_pkg` contains:
  - the `ctrl_t` packed struct;
  - the FSM state enum;
  - the opcode-class constants;
  - the ISA decode constants;
  - the `OPC_VEC_CLASS` constant.
- Sub-module `cu_decode`: combinational, `Opcode`/`Func` → `ctrl_t`.
- The top level holds the FSM, beat counter, output registers and counters.

## Test plan
- Reset with the scalar ALU op (`Opcode`=6'h01) present:
  - while `rst_n`=0, all outputs are 0;
  - on release with `InstrValid`=1, the next cycle has `CtrlValid`=1, `RegWrite`=1, `LaneMask`=4'hF, `Stall`=0.
- Vector op `Opcode`=6'h30, `BEATS`=4:
  - `LaneMask` sequence is 1,2,4,8;
  - `Stall` is 1,1,1,0;
  - `FlagWrite`≠0 only on the beat where `LaneMask`=8;
  - `RegWriteV`=1 on all four beats.
- Vector op followed by scalar op, held on the bus:
  - the scalar op issues on the cycle immediately after the beat with `LaneMask`=8;
  - no idle cycle occurs between them.
- Scalar write with `Rd`=31 and `RegWrite`=1 → `PCSrc`=1. The same write with `Rd`=3 → `PCSrc`=0.
- `Flush` asserted at vector beat 1, with `InstrValid` high:
  - next cycle `CtrlValid`=0 and `Stall`=0;
  - `RegWriteV` is not asserted for beats 2 and 3.
- With `CU_PERF_CNT_EN`, three vector ops at `BEATS`=4 → `PerfVecCnt`=3 and `PerfStallCnt`=9.
